uart_tx_frame_engine: RTL and testbench
=======================================

Name: uart_tx_frame_engine

Overview:
- Parametrised, synthesisable UART transmit engine; successor to the fixed 8-bit TX model.
- Buffers characters in a small FIFO and serialises each one onto a single lane.
- Frame shape is run-time configurable: 5–8 data bits, optional even/odd parity, 1/1.5/2 stop bits, LSB- or MSB-first, baud divisor × oversampling bit timing.
- Sits between the HVL-driven stimulus interface and the DUT rx pin in the HDL top.

Parameters:
- MAX_CHAR_LENGTH, 8, width of s_data; supported character lengths 5..MAX_CHAR_LENGTH.
- FIFO_DEPTH, 4, number of buffered characters; power of two, >=2.
- DIV_WIDTH, 16, width of cfg_baud_div.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_baud_div  in  DIV_WIDTH  baud divisor; 0 is invalid.
- cfg_oversampling  in  4  clocks-per-bit multiplier; legal values 2, 4, 6, 8.
- cfg_char_len  in  4  data bits per frame; legal values 5..MAX_CHAR_LENGTH.
- cfg_stop_bit  in  2  stop-bit code: 1 = one, 0 = one-and-half, 2 = two; 3 is invalid.
- cfg_msb_first  in  1  1 = MSB of the character first.
- cfg_parity_en  in  1  insert parity bit.
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
- s_valid  in  1  character available.
- s_ready  out  1  FIFO can accept; equals !full.
- s_data  in  MAX_CHAR_LENGTH  character; bits at and above cfg_char_len are ignored.
- tx  out  1  serial line; idle high.
- busy  out  1  1 while state != IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- cfg_err  out  1  last frame-start attempt saw an illegal config.

Behaviour:
- Reset (async, active-high) values: tx=1, busy=0, cfg_err=0, fifo_count=0, FIFO emptied, state=IDLE. s_ready reads 1 once reset deasserts.
- Push occurs on a rising edge with s_valid && s_ready. Pop is internal. Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Bit period T = cfg_baud_div × cfg_oversampling clocks. Half period H = floor(T/2).
- States:
  - IDLE: tx=1. If the FIFO is non-empty, check the config.
    - Legal config: latch all cfg_* into frame registers, pop, clear cfg_err, go to START.
    - Illegal config: set cfg_err=1, no pop, stay in IDLE, re-check every cycle.
  - START: tx=0 for T clocks, then DATA.
  - DATA: shift out char_len bits, each for T clocks. Order is bit 0 upward, or bit char_len-1 downward when msb_first. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: tx = XOR of the char_len data bits, inverted when odd parity, for T clocks.
  - STOP: tx=1 for T (one), T+H (one-and-half) or 2T (two) clocks.
    - FIFO non-empty and config legal: latch config, pop, go straight to START with no idle gap.
    - Otherwise: go to IDLE.
- Latency: a character accepted on edge N, with an empty FIFO in IDLE, is popped on edge N+1; tx falls on edge N+1.
- Config changes mid-frame have no effect on the frame in flight.
- The bit counter and clock counter reset at each state entry.
- Full FIFO: s_ready=0. Empty FIFO after STOP: return to IDLE.
- Reset mid-frame: tx returns to 1 immediately, and all buffered characters are discarded.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds port break_req (in, 1).
  - break_req=1 seen in IDLE enters BREAK: tx=0, busy=1, no pops.
  - On deassertion, hold tx=1 for one T (mark-after-break), then go to IDLE.
  - A request arriving mid-frame waits until STOP completes. It takes priority over a pending FIFO character.
- Undefined: no port, no BREAK state; behaviour is exactly as above.

Test Plan:
- 8N1 LSB-first: baud_div=2, oversampling=4 (T=8), push 0xA5 -> tx, in 8-clock slots: 0,1,0,1,0,0,1,0,1,1. Frame is 80 clocks, then busy=0.
- 7E1.5 MSB-first: push 0x55, parity_en=1, odd=0, stop_bit=0, T=8 -> data 1,0,1,0,1,0,1; parity 0; stop high for 12 clocks.
- Odd parity with two stop bits, 5-bit char 0x13 -> data LSB-first 1,1,0,0,1; parity 0; stop 16 clocks.
- Back-to-back: push 0x00, 0xFF, 0x0F -> three frames with no idle cycles between them; fifo_count peaks at 2; characters leave in order.
- Illegal config then fix: baud_div=0, push 4 chars -> cfg_err=1, s_ready=0, fifo_count=4, tx=1 throughout. Then set baud_div=1 -> cfg_err clears and 4 frames follow.
- Reset mid-DATA -> tx=1 in the same cycle, fifo_count=0, busy=0. The next push transmits normally.

Source files
------------

// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: FIFO-buffered UART transmitter with run-time frame format.
// Define UART_TX_BREAK_EN to add the break_req port and the BREAK / mark-after-break states.
module uart_tx_frame_engine #(
    parameter int MAX_CHAR_LENGTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIV_WIDTH-1:0]         cfg_baud_div,
    input  logic [3:0]                   cfg_oversampling,
    input  logic [3:0]                   cfg_char_len,
    input  logic [1:0]                   cfg_stop_bit,
    input  logic                         cfg_msb_first,
    input  logic                         cfg_parity_en,
    input  logic                         cfg_parity_odd,
`ifdef UART_TX_BREAK_EN
    input  logic                         break_req,
`endif
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [MAX_CHAR_LENGTH-1:0]   s_data,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         cfg_err
);
    localparam int MC = MAX_CHAR_LENGTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = DIV_WIDTH + 4;
    localparam int LW = TW + 1;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK, MAB} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t        state;
    logic [MC-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          brk;
    logic          cfg_ok;
    logic          start_ok;
    logic          last_tick;
    logic          stop_done;
    logic          tx_bit;
    logic [TW-1:0] cfg_t;
    logic [LW-1:0] cfg_stop_len;
    logic [LW-1:0] cnt;
    logic [LW-1:0] frame_t;
    logic [LW-1:0] frame_stop;
    logic [MC-1:0] head;
    logic [MC-1:0] lat_data;
    logic [MC-1:0] lat_shift;
    logic [MC-1:0] shreg;
    logic [MC-1:0] shifted;
    logic [3:0]    frame_len;
    logic [3:0]    bit_cnt;
    logic          frame_msb;
    logic          frame_par_en;
    logic          frame_par;

`ifdef UART_TX_BREAK_EN
    assign brk = break_req;
`else
    assign brk = 1'b0;
`endif

    assign s_ready = fifo_count != CW'(FIFO_DEPTH);
    assign push = s_valid && s_ready;
    assign head = mem[rd_ptr];
    assign cfg_t = TW'(cfg_baud_div) * TW'(cfg_oversampling);
    assign cfg_stop_len = cfg_stop_bit == 2'd2 ? {cfg_t, 1'b0} :
                          cfg_stop_bit == 2'd0 ? LW'(cfg_t) + LW'(cfg_t >> 1) : LW'(cfg_t);
    assign cfg_ok = (cfg_baud_div != '0) && (cfg_oversampling inside {4'd2, 4'd4, 4'd6, 4'd8}) &&
                    (cfg_char_len >= 4'd5) && (cfg_char_len <= 4'(MC)) && (cfg_stop_bit != 2'd3);
    // MSB-first characters are left-aligned so both orders shift out of a fixed end
    assign lat_data = head & ~({MC{1'b1}} << cfg_char_len);
    assign lat_shift = cfg_msb_first ? lat_data << (4'(MC) - cfg_char_len) : lat_data;
    assign start_ok = (fifo_count != '0) && cfg_ok && !brk;
    assign last_tick = cnt == frame_t - 1'b1;
    assign stop_done = cnt == frame_stop - 1'b1;
    assign pop = start_ok && (state == IDLE || (state == STOP && stop_done));
    assign tx_bit = frame_msb ? shreg[MC-1] : shreg[0];
    assign shifted = frame_msb ? shreg << 1 : shreg >> 1;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tx <= 1'b1;
            busy <= 1'b0;
            cfg_err <= 1'b0;
            cnt <= '0;
            bit_cnt <= '0;
            shreg <= '0;
            frame_t <= '0;
            frame_stop <= '0;
            frame_len <= '0;
            frame_msb <= 1'b0;
            frame_par_en <= 1'b0;
            frame_par <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (pop) begin
                state <= START;
                tx <= 1'b0;
                busy <= 1'b1;
                cfg_err <= 1'b0;
                cnt <= '0;
                frame_t <= LW'(cfg_t);
                frame_stop <= cfg_stop_len;
                frame_len <= cfg_char_len;
                frame_msb <= cfg_msb_first;
                frame_par_en <= cfg_parity_en;
                frame_par <= ^lat_data ^ cfg_parity_odd;
                shreg <= lat_shift;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (fifo_count != '0 && !brk)
                            cfg_err <= 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (brk) begin
                            state <= BREAK;
                            tx <= 1'b0;
                            busy <= 1'b1;
                            frame_t <= LW'(cfg_t);
                        end
`endif
                    end
                    START: begin
                        if (last_tick) begin
                            state <= DATA;
                            tx <= tx_bit;
                            shreg <= shifted;
                            bit_cnt <= '0;
                            cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (last_tick) begin
                            cnt <= '0;
                            if (bit_cnt == frame_len - 1'b1) begin
                                state <= frame_par_en ? PARITY : STOP;
                                tx <= frame_par_en ? frame_par : 1'b1;
                            end else begin
                                tx <= tx_bit;
                                shreg <= shifted;
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        if (last_tick) begin
                            state <= STOP;
                            tx <= 1'b1;
                            cnt <= '0;
                        end
                    end
                    STOP: begin
                        // no pop here means the FIFO is empty, a break is pending, or the config is illegal
                        if (stop_done) begin
                            state <= IDLE;
                            busy <= 1'b0;
                            cnt <= '0;
                            if (fifo_count != '0 && !brk)
                                cfg_err <= 1'b1;
                        end
                    end
`ifdef UART_TX_BREAK_EN
                    BREAK: begin
                        cnt <= '0;
                        if (!brk) begin
                            state <= MAB;
                            tx <= 1'b1;
                        end
                    end
                    MAB: begin
                        if (last_tick) begin
                            state <= IDLE;
                            busy <= 1'b0;
                            cnt <= '0;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb_uart_tx_frame_engine: directed stimulus with an expected-frame queue checked by a line monitor.
module tb_uart_tx_frame_engine;
    typedef struct {
        logic [11:0] bits;
        int          n;
        int          t;
        int          stop;
        bit          chain;
        int          id;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_baud_div = 16'd2;
    logic [3:0]  cfg_oversampling = 4'd4;
    logic [3:0]  cfg_char_len = 4'd8;
    logic [1:0]  cfg_stop_bit = 2'd1;
    logic        cfg_msb_first = 1'b0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        cfg_err;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     next_id = 0;
    bit     mon_busy = 0;
    bit     track = 0;
    int     peak = 0;

    uart_tx_frame_engine dut (
        .clk(clk),
        .rst(rst),
        .cfg_baud_div(cfg_baud_div),
        .cfg_oversampling(cfg_oversampling),
        .cfg_char_len(cfg_char_len),
        .cfg_stop_bit(cfg_stop_bit),
        .cfg_msb_first(cfg_msb_first),
        .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (track && int'(fifo_count) > peak)
            peak = int'(fifo_count);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // slot 0 is the leftmost of the n listed bits (start bit first)
    task automatic expect_frame(input logic [11:0] bits, input int n, input int t, input int stop, input bit chain);
        frame_t f;
        f.bits = bits;
        f.n = n;
        f.t = t;
        f.stop = stop;
        f.chain = chain;
        f.id = next_id++;
        exp_q.push_back(f);
    endtask

    task automatic push_char(input logic [7:0] d);
        s_data = d;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || mon_busy) && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_drain"}, 32'(exp_q.size() != 0 || mon_busy), 32'd0);
        #1;
    endtask

    initial begin : monitor
        frame_t f;
        bit     pre;
        bit     aborted;
        logic   got;
        logic   want;
        pre = 0;
        forever begin
            if (!pre)
                @(negedge clk);
            pre = 0;
            if (rst || tx !== 1'b0)
                continue;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                while (tx === 1'b0 && !rst)
                    @(negedge clk);
                continue;
            end
            f = exp_q.pop_front();
            mon_busy = 1;
            aborted = 0;
            for (int s = 0; s < f.n && !aborted; s++) begin
                want = f.bits[4'(f.n - 1 - s)];
                got = want;
                for (int c = 0; c < f.t && !aborted; c++) begin
                    if (s != 0 || c != 0)
                        @(negedge clk);
                    if (rst)
                        aborted = 1;
                    else if (tx !== want)
                        got = tx;
                end
                if (!aborted)
                    check($sformatf("f%0d_slot%0d", f.id, s), 32'(got), 32'(want));
            end
            got = 1'b1;
            for (int c = 0; c < f.stop && !aborted; c++) begin
                @(negedge clk);
                if (rst)
                    aborted = 1;
                else if (tx !== 1'b1)
                    got = tx;
            end
            if (!aborted) begin
                check($sformatf("f%0d_stop", f.id), 32'(got), 32'd1);
                @(negedge clk);
                if (f.chain) begin
                    check($sformatf("f%0d_no_gap", f.id), 32'(tx), 32'd0);
                    pre = 1;
                end else begin
                    check($sformatf("f%0d_end_busy", f.id), 32'(busy), 32'd0);
                end
            end
            mon_busy = 0;
        end
    end

    initial begin : stimulus
        bit low_seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // 8N1 LSB-first, T=8
        expect_frame(12'b010100101, 9, 8, 8, 0);
        push_char(8'hA5);
        check("lat_count_after_push", 32'(fifo_count), 32'd1);
        @(posedge clk);
        #1;
        check("lat_tx_low", 32'(tx), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_popped", 32'(fifo_count), 32'd0);
        drain("8n1", 200);

        // 7E1.5 MSB-first; bit 7 of the character must be ignored
        cfg_char_len = 4'd7;
        cfg_msb_first = 1'b1;
        cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b0;
        cfg_stop_bit = 2'd0;
        expect_frame(12'b010101010, 9, 8, 12, 0);
        push_char(8'hD5);
        drain("7e15", 200);

        // 5O2 LSB-first; bits 7..5 ignored
        cfg_char_len = 4'd5;
        cfg_msb_first = 1'b0;
        cfg_parity_odd = 1'b1;
        cfg_stop_bit = 2'd2;
        expect_frame(12'b0110010, 7, 8, 16, 0);
        push_char(8'hF3);
        drain("5o2", 200);

        // back-to-back 8N1
        cfg_char_len = 4'd8;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_stop_bit = 2'd1;
        peak = 0;
        track = 1;
        expect_frame(12'b000000000, 9, 8, 8, 1);
        expect_frame(12'b011111111, 9, 8, 8, 1);
        expect_frame(12'b011110000, 9, 8, 8, 0);
        push_char(8'h00);
        push_char(8'hFF);
        push_char(8'h0F);
        drain("b2b", 400);
        track = 0;
        check("b2b_peak_count", 32'(peak), 32'd2);

        // illegal baud divisor holds characters in the FIFO
        cfg_baud_div = 16'd0;
        push_char(8'h12);
        push_char(8'h34);
        push_char(8'h56);
        push_char(8'h78);
        push_char(8'h9A);
        low_seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 low_seen |= !tx;
        end
        check("illegal_tx_idle", 32'(low_seen), 32'd0);
        check("illegal_cfg_err", 32'(cfg_err), 32'd1);
        check("illegal_s_ready", 32'(s_ready), 32'd0);
        check("illegal_count", 32'(fifo_count), 32'd4);
        check("illegal_busy", 32'(busy), 32'd0);
        expect_frame(12'b001001000, 9, 4, 4, 1);
        expect_frame(12'b000101100, 9, 4, 4, 1);
        expect_frame(12'b001101010, 9, 4, 4, 1);
        expect_frame(12'b000011110, 9, 4, 4, 0);
        cfg_baud_div = 16'd1;
        @(posedge clk);
        #1;
        check("fixed_cfg_err_clear", 32'(cfg_err), 32'd0);
        check("fixed_count", 32'(fifo_count), 32'd3);
        drain("fixed", 400);

        // reset in the middle of DATA discards the frame and the buffered character
        cfg_baud_div = 16'd2;
        expect_frame(12'b011000011, 9, 8, 8, 0);
        push_char(8'hC3);
        push_char(8'h3C);
        repeat (24) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        drain("midrst", 20);
        expect_frame(12'b010000001, 9, 8, 8, 0);
        push_char(8'h81);
        drain("after_rst", 200);
        repeat (30) @(posedge clk);
        #1;
        check("final_idle_tx", 32'(tx), 32'd1);
        check("final_count", 32'(fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
